// File: rtl/mem_walker_loop_ctrl_if.sv
// Handshake/config bundle between a loop-nest driver and mem_walker_loop_ctrl.
// The controller takes the slave modport; the stimulus side takes the master modport.
interface mem_walker_loop_ctrl_if #(
    parameter int unsigned LOOP_ID_W     = 5,
    parameter int unsigned NUM_MAX_LOOPS = (1 << LOOP_ID_W),
    parameter int unsigned LOOP_ITER_W   = 16
);
    logic                     cfg_loop_iter_v;
    logic [LOOP_ID_W-1:0]     cfg_loop_id;
    logic [LOOP_ITER_W-1:0]   cfg_loop_iter;
    logic                     start_req;
    logic                     stall_in;
    logic                     busy;
    logic                     start;
    logic                     stall;
    logic [NUM_MAX_LOOPS:0]   iter_done;
    logic                     block_done;
    logic                     done;

    modport master (
        output cfg_loop_iter_v, cfg_loop_id, cfg_loop_iter, start_req, stall_in,
        input  busy, start, stall, iter_done, block_done, done
    );

    modport slave (
        input  cfg_loop_iter_v, cfg_loop_id, cfg_loop_iter, start_req, stall_in,
        output busy, start, stall, iter_done, block_done, done
    );
endinterface

// File: rtl/mem_walker_loop_ctrl.sv
// Loop-nest sequencer for the strided memory walker (loop 0 outermost).
// Optional perf counters enabled by defining MEM_WALKER_LOOP_CTRL_PERF_EN.
module mem_walker_loop_ctrl #(
    parameter int unsigned LOOP_ID_W     = 5,
    parameter int unsigned NUM_MAX_LOOPS = (1 << LOOP_ID_W),
    parameter int unsigned LOOP_ITER_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_walker_loop_ctrl_if.slave   bus
`ifdef MEM_WALKER_LOOP_CTRL_PERF_EN
    ,
    output logic [31:0]             perf_run_cycles,
    output logic [31:0]             perf_stall_cycles
`endif
);

    localparam int unsigned N = NUM_MAX_LOOPS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [LOOP_ITER_W-1:0]   iter_q [N];
    logic [LOOP_ITER_W-1:0]   iter_d [N];
    logic [LOOP_ITER_W-1:0]   cnt_q  [N];
    logic [LOOP_ITER_W-1:0]   cnt_d  [N];
    logic [N-1:0]             last;
    logic [N:0]               wrap;
    logic                     step;
    logic                     cfg_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            for (int unsigned k = 0; k < N; k++) begin
                iter_q[k] <= LOOP_ITER_W'(1);
                cnt_q[k]  <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int unsigned k = 0; k < N; k++) begin
                iter_q[k] <= iter_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

    // A stored count of 0 behaves as 1, so the loop's final index is max(iter,1)-1.
    always_comb begin
        last = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (iter_q[k] == '0) begin
                last[k] = (cnt_q[k] == '0);
            end else begin
                last[k] = (cnt_q[k] == iter_q[k] - LOOP_ITER_W'(1));
            end
        end
    end

    // wrap[k]: loops k..N-1 are all on their final index; wrap[N] is the empty product.
    always_comb begin : wrap_chain
        logic acc;
        acc     = 1'b1;
        wrap    = '0;
        wrap[N] = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
            acc             = acc & last[N-1-i];
            wrap[N-1-i]     = acc;
        end
    end

    assign step = (state_q == S_RUN) && !bus.stall_in;

    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            cnt_d[k] = cnt_q[k];
            if (step) begin
                if (wrap[k]) begin
                    cnt_d[k] = '0;
                end else if (wrap[k+1]) begin
                    cnt_d[k] = cnt_q[k] + LOOP_ITER_W'(1);
                end
            end
        end
    end

    assign cfg_ok = bus.cfg_loop_iter_v && (state_q == S_IDLE || state_q == S_START)
                    && (32'(bus.cfg_loop_id) < N);

    always_comb begin
        iter_d = iter_q;
        if (cfg_ok) begin
            iter_d[bus.cfg_loop_id] = bus.cfg_loop_iter;
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.busy       = 1'b0;
        bus.start      = 1'b0;
        bus.done       = 1'b0;
        bus.block_done = 1'b0;
        bus.iter_done  = '0;
        bus.stall      = bus.stall_in;
        case (state_q)
            S_IDLE: begin
                if (bus.start_req) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                bus.busy  = 1'b1;
                bus.start = 1'b1;
                state_d   = S_RUN;
            end
            S_RUN: begin
                bus.busy = 1'b1;
                if (step) begin
                    bus.iter_done = wrap;
                    if (wrap[0]) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                bus.busy       = 1'b1;
                bus.done       = 1'b1;
                bus.block_done = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MEM_WALKER_LOOP_CTRL_PERF_EN
    logic [31:0] perf_run_q, perf_stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_run_q   <= '0;
            perf_stall_q <= '0;
        end else if (state_q == S_START) begin
            perf_run_q   <= '0;
            perf_stall_q <= '0;
        end else if (state_q == S_RUN) begin
            if (perf_run_q != '1) begin
                perf_run_q <= perf_run_q + 32'd1;
            end
            if (bus.stall_in && perf_stall_q != '1) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_run_cycles   = perf_run_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_walker_loop_ctrl.sv
// Self-checking bench for mem_walker_loop_ctrl: directed passes plus randomized
// loop counts and stalls, checked against a mixed-radix step model.
module tb_mem_walker_loop_ctrl;

    localparam int unsigned LID = 5;
    localparam int unsigned LIT = 16;
    localparam int unsigned N   = (1 << LID);

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_walker_loop_ctrl_if #(.LOOP_ID_W(LID), .NUM_MAX_LOOPS(N), .LOOP_ITER_W(LIT)) bus ();

`ifdef MEM_WALKER_LOOP_CTRL_PERF_EN
    logic [31:0] perf_run_cycles;
    logic [31:0] perf_stall_cycles;
`endif

    mem_walker_loop_ctrl #(.LOOP_ID_W(LID), .NUM_MAX_LOOPS(N), .LOOP_ITER_W(LIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef MEM_WALKER_LOOP_CTRL_PERF_EN
        ,
        .perf_run_cycles   (perf_run_cycles),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    int total = 0;
    int bad   = 0;
    int unsigned model_iter [N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint eff(input int k);
        return (model_iter[k] == 0) ? 64'd1 : longint'(model_iter[k]);
    endfunction

    function automatic longint pass_steps();
        longint p = 1;
        for (int k = 0; k < N; k++) p *= eff(k);
        return p;
    endfunction

    // Step s (1-based) wraps loop k when s is a multiple of the product of counts k..N-1.
    function automatic logic [N:0] exp_vec(input longint s);
        logic [N:0] v;
        longint prod = 1;
        v    = '0;
        v[N] = 1'b1;
        for (int k = N - 1; k >= 0; k--) begin
            prod *= eff(k);
            v[k] = ((s % prod) == 0);
        end
        return v;
    endfunction

    task automatic cfg(input int id, input int unsigned val);
        @(negedge clk);
        bus.cfg_loop_iter_v = 1'b1;
        bus.cfg_loop_id     = LID'(id);
        bus.cfg_loop_iter   = LIT'(val);
        model_iter[id]      = val;
        @(negedge clk);
        bus.cfg_loop_iter_v = 1'b0;
    endtask

    task automatic do_pass(input bit rnd_stall, input int stall_at, input int stall_len,
                           input bit cfg_mid, input bit cfg_with_start);
        longint tot;
        longint steps = 0;
        int     c = 0;
        int     stalls = 0;
        bit     st;
        @(negedge clk);
        bus.start_req = 1'b1;
        if (cfg_with_start) begin
            bus.cfg_loop_iter_v = 1'b1;
            bus.cfg_loop_id     = LID'(5);
            bus.cfg_loop_iter   = LIT'(2);
            model_iter[5]       = 2;
        end
        tot = pass_steps();
        #1;
        check("idle_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        bus.start_req       = 1'b0;
        bus.cfg_loop_iter_v = 1'b0;
        #1;
        check("start_pulse", 64'(bus.start), 64'd1);
        check("start_busy", 64'(bus.busy), 64'd1);
        check("start_iter_done", 64'(bus.iter_done), 64'd0);
        while (steps < tot && c < 2000) begin
            @(negedge clk);
            st = (c >= stall_at && c < stall_at + stall_len) ||
                 (rnd_stall && $urandom_range(0, 3) == 0);
            bus.stall_in  = st;
            bus.start_req = (c == 1);
            if (cfg_mid && c == 2) begin
                bus.cfg_loop_iter_v = 1'b1;
                bus.cfg_loop_id     = LID'(N - 1);
                bus.cfg_loop_iter   = LIT'(5);
            end else begin
                bus.cfg_loop_iter_v = 1'b0;
            end
            #1;
            check("stall_pass", 64'(bus.stall), 64'(st));
            check("run_done_low", 64'(bus.done), 64'd0);
            if (st) begin
                check("iter_done_stall", 64'(bus.iter_done), 64'd0);
                stalls++;
            end else begin
                steps++;
                check("iter_done_step", 64'(bus.iter_done), 64'(exp_vec(steps)));
            end
            c++;
        end
        if (c >= 2000) check("pass_timeout", 64'd1, 64'd0);
        @(negedge clk);
        bus.stall_in        = 1'b0;
        bus.cfg_loop_iter_v = 1'b0;
        bus.start_req       = 1'b1;
        #1;
        check("done_pulse", 64'(bus.done), 64'd1);
        check("block_done_pulse", 64'(bus.block_done), 64'd1);
        check("done_busy", 64'(bus.busy), 64'd1);
        check("done_iter_done", 64'(bus.iter_done), 64'd0);
`ifdef MEM_WALKER_LOOP_CTRL_PERF_EN
        check("perf_run", 64'(perf_run_cycles), 64'(c));
        check("perf_stall", 64'(perf_stall_cycles), 64'(stalls));
`endif
        @(negedge clk);
        bus.start_req = 1'b0;
        #1;
        check("after_busy", 64'(bus.busy), 64'd0);
        check("after_done", 64'(bus.done), 64'd0);
        check("after_block_done", 64'(bus.block_done), 64'd0);
        check("after_start_ignored", 64'(bus.start), 64'd0);
`ifdef MEM_WALKER_LOOP_CTRL_PERF_EN
        check("perf_run_hold", 64'(perf_run_cycles), 64'(c));
        check("perf_stall_hold", 64'(perf_stall_cycles), 64'(stalls));
`endif
    endtask

    initial begin
        for (int k = 0; k < N; k++) model_iter[k] = 1;
        reset               = 1'b1;
        bus.cfg_loop_iter_v = 1'b0;
        bus.cfg_loop_id     = '0;
        bus.cfg_loop_iter   = '0;
        bus.start_req       = 1'b0;
        bus.stall_in        = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_start", 64'(bus.start), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_block_done", 64'(bus.block_done), 64'd0);
        check("rst_iter_done", 64'(bus.iter_done), 64'd0);
        check("rst_stall", 64'(bus.stall), 64'd0);
`ifdef MEM_WALKER_LOOP_CTRL_PERF_EN
        check("rst_perf_run", 64'(perf_run_cycles), 64'd0);
        check("rst_perf_stall", 64'(perf_stall_cycles), 64'd0);
`endif
        reset = 1'b0;

        // Default counts: one step, all wrap bits set.
        do_pass(1'b0, 1000, 0, 1'b0, 1'b0);

        cfg(N - 1, 3);
        cfg(N - 2, 2);
        do_pass(1'b0, 1000, 0, 1'b0, 1'b0);
        do_pass(1'b0, 2, 4, 1'b0, 1'b0);

        // Mid-run write is dropped; model keeps 3, so the following pass stays 6 steps.
        do_pass(1'b0, 1000, 0, 1'b1, 1'b0);
        do_pass(1'b0, 1000, 0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a pass.
        @(negedge clk);
        bus.start_req = 1'b1;
        @(negedge clk);
        bus.start_req = 1'b0;
        @(negedge clk);
        #1;
        check("pre_reset_step1", 64'(bus.iter_done), 64'(exp_vec(1)));
        @(negedge clk);
        #1;
        check("pre_reset_step2", 64'(bus.iter_done), 64'(exp_vec(2)));
        #1;
        reset = 1'b1;
        #1;
        check("mid_reset_busy", 64'(bus.busy), 64'd0);
        check("mid_reset_done", 64'(bus.done), 64'd0);
        check("mid_reset_iter_done", 64'(bus.iter_done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < N; k++) model_iter[k] = 1;
        #1;
        check("post_reset_done", 64'(bus.done), 64'd0);
        do_pass(1'b0, 1000, 0, 1'b0, 1'b0);

        // Config written in the same cycle as start_req is used by that pass.
        cfg(N - 1, 3);
        cfg(N - 2, 2);
        cfg(0, 0);
        do_pass(1'b0, 1, 4, 1'b0, 1'b1);

        for (int r = 0; r < 4; r++) begin
            for (int k = N - 4; k < N; k++) cfg(k, $urandom_range(0, 3));
            cfg(int'($urandom_range(0, N - 5)), $urandom_range(1, 2));
            do_pass(1'b1, 1000, 0, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
